// File: rtl/ppu_oam_scan.sv
// Mode-2 OAM search: sweeps every OAM entry for one scanline and buffers up to
// MAX_SPRITES sprites whose vertical extent covers LY, in ascending OAM order.
module ppu_oam_scan #(
  parameter int NUM_ENTRIES = 40,
  parameter int MAX_SPRITES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  LY,
  input  logic        obj_size,
  output logic        oam_rd,
  output logic [6:0]  oam_addr,
  input  logic [15:0] oam_data,
  output logic        busy,
  output logic        done,
  output logic [3:0]  sprite_count,
  input  logic [3:0]  buf_rd_idx,
  output logic        buf_valid,
  output logic [7:0]  buf_x,
  output logic [7:0]  buf_tile,
  output logic [7:0]  buf_attr,
  output logic [3:0]  buf_row,
  output logic [5:0]  buf_oam_idx
);

  localparam logic [6:0] LAST_ADDR = 7'(2 * NUM_ENTRIES - 1);
  localparam logic [3:0] MAX_CNT   = 4'(MAX_SPRITES);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [6:0] addr_q;
  logic [3:0] count_q;
  logic [7:0] ly_q;
  logic       size_q;
  logic       start_ok;

  // Screen line in OAM coordinates: sprite Y is offset by 16 so that
  // partially visible sprites at the top edge have non-negative Y.
  function automatic logic [8:0] line_pos(input logic [7:0] ly);
    return {1'b0, ly} + 9'd16;
  endfunction

  function automatic logic covers_line(input logic [7:0] ly, input logic tall,
                                       input logic [7:0] y);
    logic [8:0] pos;
    logic [8:0] top;
    logic [8:0] h;
    pos = line_pos(ly);
    top = {1'b0, y};
    h   = tall ? 9'd16 : 9'd8;
    return (pos >= top) && (pos < top + h);
  endfunction

  function automatic logic [3:0] sprite_row(input logic [7:0] ly, input logic [7:0] y);
    return 4'(line_pos(ly) - {1'b0, y});
  endfunction

  // Tall sprites address an even/odd tile pair, so the stored base is even.
  function automatic logic [7:0] sprite_tile(input logic [7:0] tile, input logic tall);
    return tall ? {tile[7:1], 1'b0} : tile;
  endfunction

  assign start_ok = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (addr_q == LAST_ADDR) state_nxt = FLUSH;
      FLUSH:   state_nxt = DONE;
      DONE:    state_nxt = start ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    oam_rd = (state == SCAN);
    busy   = (state == SCAN) || (state == FLUSH);
    done   = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst)                                     addr_q <= '0;
    else if (state == SCAN && addr_q != LAST_ADDR) addr_q <= addr_q + 7'd1;
    else                                         addr_q <= '0;
  end

  assign oam_addr = addr_q;

  always_ff @(posedge clk) begin
    if (start_ok) begin
      ly_q   <= LY;
      size_q <= obj_size;
    end
  end

  // Stage p0: read strobe and address delayed to line up with oam_data
  logic       vld_p0;
  logic [6:0] addr_p0;

  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= oam_rd;
  end

  always_ff @(posedge clk) addr_p0 <= oam_addr;

  // Stage p1: {X,Y} half of the entry held until its {attr,tile} half arrives
  logic [7:0] y_p1;
  logic [7:0] x_p1;

  always_ff @(posedge clk) begin
    if (vld_p0 && !addr_p0[0]) begin
      y_p1 <= oam_data[7:0];
      x_p1 <= oam_data[15:8];
    end
  end

  logic eval_p0;
  logic hit_p0;
  logic wr_p0;

  assign eval_p0 = vld_p0 && addr_p0[0];
  assign hit_p0  = covers_line(ly_q, size_q, y_p1);
  assign wr_p0   = eval_p0 && hit_p0 && (count_q < MAX_CNT);

  always_ff @(posedge clk) begin
    if (rst)           count_q <= '0;
    else if (start_ok) count_q <= '0;
    else if (wr_p0)    count_q <= count_q + 4'd1;
  end

  assign sprite_count = count_q;

  // Sprite buffer: contents only meaningful below count_q
  logic [7:0] mem_x    [MAX_SPRITES];
  logic [7:0] mem_tile [MAX_SPRITES];
  logic [7:0] mem_attr [MAX_SPRITES];
  logic [3:0] mem_row  [MAX_SPRITES];
  logic [5:0] mem_idx  [MAX_SPRITES];

  always_ff @(posedge clk) begin
    if (wr_p0) begin
      mem_x[count_q]    <= x_p1;
      mem_tile[count_q] <= sprite_tile(oam_data[7:0], size_q);
      mem_attr[count_q] <= oam_data[15:8];
      mem_row[count_q]  <= sprite_row(ly_q, y_p1);
      mem_idx[count_q]  <= addr_p0[6:1];
    end
  end

  assign buf_valid = (buf_rd_idx < count_q);

  always_comb begin
    buf_x       = '0;
    buf_tile    = '0;
    buf_attr    = '0;
    buf_row     = '0;
    buf_oam_idx = '0;
    if (buf_rd_idx < MAX_CNT) begin
      buf_x       = mem_x[buf_rd_idx];
      buf_tile    = mem_tile[buf_rd_idx];
      buf_attr    = mem_attr[buf_rd_idx];
      buf_row     = mem_row[buf_rd_idx];
      buf_oam_idx = mem_idx[buf_rd_idx];
    end
  end

endmodule

// File: tb/tb_ppu_oam_scan.sv
// Bench for ppu_oam_scan: OAM memory model, spec-level reference model of
// scan timing and sprite selection, per-cycle compare plus directed pins.
`timescale 1ns/1ps
module tb_ppu_oam_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  LY = 8'd0;
  logic        obj_size = 1'b0;
  logic        oam_rd;
  logic [6:0]  oam_addr;
  logic [15:0] oam_data = 16'd0;
  logic        busy;
  logic        done;
  logic [3:0]  sprite_count;
  logic [3:0]  buf_rd_idx;
  logic        buf_valid;
  logic [7:0]  buf_x;
  logic [7:0]  buf_tile;
  logic [7:0]  buf_attr;
  logic [3:0]  buf_row;
  logic [5:0]  buf_oam_idx;

  ppu_oam_scan dut (
    .clk(clk), .rst(rst), .start(start), .LY(LY), .obj_size(obj_size),
    .oam_rd(oam_rd), .oam_addr(oam_addr), .oam_data(oam_data),
    .busy(busy), .done(done), .sprite_count(sprite_count),
    .buf_rd_idx(buf_rd_idx), .buf_valid(buf_valid), .buf_x(buf_x),
    .buf_tile(buf_tile), .buf_attr(buf_attr), .buf_row(buf_row),
    .buf_oam_idx(buf_oam_idx)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // OAM memory: data one cycle after the strobe, garbage otherwise
  logic [15:0] oam_mem [80];
  always @(posedge clk) oam_data <= oam_rd ? oam_mem[oam_addr] : 16'($urandom);

  // Buffer read index: random unless the directed code pins it
  bit         idx_hold = 1'b1;
  logic [3:0] idx_req  = 4'd0;
  logic [3:0] idx_rand = 4'd0;
  assign buf_rd_idx = idx_hold ? idx_req : idx_rand;
  initial forever begin
    @(posedge clk);
    #2 idx_rand = 4'($urandom_range(0, 15));
  end

  // Reference model
  int mcyc     = 0;
  int idle_cnt = 0;
  int m_n      = 0;
  bit m_hit [40];
  int e_x [10];
  int e_tile [10];
  int e_attr [10];
  int e_row [10];
  int e_idx [10];

  function automatic void build_model(input int ly, input bit sz);
    int lyp;
    int h;
    int y;
    int x;
    int t;
    int a;
    lyp = ly + 16;
    h   = sz ? 16 : 8;
    m_n = 0;
    for (int i = 0; i < 40; i++) begin
      y = int'(oam_mem[2*i][7:0]);
      x = int'(oam_mem[2*i][15:8]);
      t = int'(oam_mem[2*i+1][7:0]);
      a = int'(oam_mem[2*i+1][15:8]);
      m_hit[i] = (lyp >= y) && (lyp < y + h);
      if (m_hit[i] && m_n < 10) begin
        e_x[m_n]    = x;
        e_tile[m_n] = sz ? (t & 'hFE) : t;
        e_attr[m_n] = a;
        e_row[m_n]  = (lyp - y) % 16;
        e_idx[m_n]  = i;
        m_n++;
      end
    end
  endfunction

  // Entry i becomes visible in the count on scan cycle 2i+4.
  function automatic int live_cnt();
    int c;
    if (mcyc == 0) return idle_cnt;
    c = 0;
    for (int i = 0; i < 40; i++)
      if (m_hit[i] && (2*i + 4) <= mcyc) c++;
    return (c > 10) ? 10 : c;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mcyc = 0;
      idle_cnt = 0;
    end else if (start && (mcyc == 0 || mcyc == 82)) begin
      build_model(int'(LY), obj_size);
      mcyc = 1;
    end else if (mcyc == 82) begin
      idle_cnt = m_n;
      mcyc = 0;
    end else if (mcyc > 0) begin
      mcyc++;
    end
  end

  always @(negedge clk) begin
    int ec;
    ec = live_cnt();
    chk("oam_rd", oam_rd, (mcyc >= 1 && mcyc <= 80));
    if (mcyc >= 1 && mcyc <= 80) chk("oam_addr", oam_addr, mcyc - 1);
    chk("busy", busy, (mcyc >= 1 && mcyc <= 81));
    chk("done", done, (mcyc == 82));
    chk("sprite_count", sprite_count, ec);
    chk("buf_valid", buf_valid, (int'(buf_rd_idx) < ec));
    if (int'(buf_rd_idx) < ec) begin
      chk("buf_x", buf_x, e_x[buf_rd_idx]);
      chk("buf_tile", buf_tile, e_tile[buf_rd_idx]);
      chk("buf_attr", buf_attr, e_attr[buf_rd_idx]);
      chk("buf_row", buf_row, e_row[buf_rd_idx]);
      chk("buf_oam_idx", buf_oam_idx, e_idx[buf_rd_idx]);
    end
  end

  task automatic clear_oam();
    for (int i = 0; i < 80; i++) oam_mem[i] = 16'h0000;
  endtask

  task automatic set_entry(input int i, input int y, input int x, input int tile, input int attr);
    oam_mem[2*i]   = {8'(x), 8'(y)};
    oam_mem[2*i+1] = {8'(attr), 8'(tile)};
  endtask

  task automatic fill_random(input int ly);
    int y;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0) y = (ly + 16 - int'($urandom_range(0, 20))) & 255;
      else                           y = int'($urandom_range(0, 255));
      set_entry(i, y, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)));
    end
  endtask

  // Called at +1 after an edge; returns at +1 of scan cycle 1.
  task automatic kick(input int ly, input bit sz);
    LY = 8'(ly);
    obj_size = sz;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int c0);
    int cyc;
    cyc = c0;
    while (!done && cyc < 250) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("done_cycle", cyc, 82);
  endtask

  task automatic scan(input int ly, input bit sz);
    @(posedge clk);
    #1 kick(ly, sz);
    wait_done(1);
  endtask

  task automatic rd(input int idx);
    idx_req = 4'(idx);
    #1;
  endtask

  initial begin
    int ly;
    int seen;
    clear_oam();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_oam_rd", oam_rd, 0);
    chk("rst_oam_addr", oam_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", sprite_count, 0);
    chk("rst_buf_valid", buf_valid, 0);

    // Single 8x8 sprite at the top of the screen
    set_entry(0, 16, 8, 'h12, 'h80);
    scan(0, 1'b0);
    chk("t1_model_n", m_n, 1);
    chk("t1_count", sprite_count, 1);
    rd(0);
    chk("t1_x", buf_x, 8);
    chk("t1_tile", buf_tile, 'h12);
    chk("t1_attr", buf_attr, 'h80);
    chk("t1_row", buf_row, 0);
    chk("t1_oam_idx", buf_oam_idx, 0);
    rd(1);
    chk("t1_idx1_valid", buf_valid, 0);

    // Vertical boundary: Y=27 is one line short of LY=10
    clear_oam();
    set_entry(3, 20, 50, 1, 2);
    set_entry(7, 26, 60, 3, 4);
    set_entry(9, 27, 70, 5, 6);
    scan(10, 1'b0);
    chk("t2_model_n", m_n, 2);
    chk("t2_count", sprite_count, 2);
    rd(0);
    chk("t2_idx0_oam", buf_oam_idx, 3);
    chk("t2_idx0_row", buf_row, 6);
    rd(1);
    chk("t2_idx1_oam", buf_oam_idx, 7);
    chk("t2_idx1_row", buf_row, 0);
    rd(2);
    chk("t2_idx2_valid", buf_valid, 0);

    // 8x16 sprite, then the same OAM in 8x8 mode
    clear_oam();
    set_entry(2, 10, 30, 'h35, 'h11);
    scan(5, 1'b1);
    chk("t3_model_n", m_n, 1);
    chk("t3_count", sprite_count, 1);
    rd(0);
    chk("t3_row", buf_row, 11);
    chk("t3_tile", buf_tile, 'h34);
    chk("t3_oam_idx", buf_oam_idx, 2);
    scan(5, 1'b0);
    chk("t3_small_model_n", m_n, 0);
    chk("t3_small_count", sprite_count, 0);

    // Every entry matches: capacity limit, OAM order
    clear_oam();
    for (int i = 0; i < 40; i++) set_entry(i, 16, 0, i, 0);
    scan(0, 1'b0);
    chk("t4_count", sprite_count, 10);
    for (int k = 0; k < 10; k++) begin
      rd(k);
      chk("t4_oam_idx", buf_oam_idx, k);
    end
    rd(10);
    chk("t4_idx10_valid", buf_valid, 0);

    // start mid-scan ignored; start in DONE begins a new scan at once
    idx_hold = 1'b0;
    ly = 60;
    fill_random(ly);
    @(posedge clk);
    #1 kick(ly, 1'b0);
    repeat (39) @(posedge clk);
    #1 kick(ly + 3, 1'b1);
    wait_done(41);
    kick(ly + 1, 1'b1);
    chk("t5_redo_busy", busy, 1);
    chk("t5_redo_rd", oam_rd, 1);
    chk("t5_redo_addr", oam_addr, 0);
    wait_done(1);

    // Reset during scan cycle 30
    ly = 100;
    fill_random(ly);
    @(posedge clk);
    #1 kick(ly, 1'b1);
    repeat (29) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_count", sprite_count, 0);
    chk("t6_oam_rd", oam_rd, 0);
    seen = 0;
    repeat (90) begin
      @(posedge clk);
      #1 if (done) seen++;
    end
    chk("t6_no_done", seen, 0);
    scan(ly, 1'b0);

    // Random lines
    repeat (20) begin
      ly = int'($urandom_range(0, 255));
      fill_random(ly);
      scan(ly, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (tests=%0d failed=%0d)", n_tests, n_fail);
    $fatal(1);
  end

endmodule
